program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction-memory interface: receives a program as a byte stream, assembles 10-bit instructions and writes them sequentially into instruction memory from address 0.
- Holds the CPU in reset while a load is in progress.
- Sits between a host byte source (UART RX or testbench) and the instruction memory write port; cpu_hold is ORed into the CPU reset.

Parameters:
ADDR_W, 8, instruction memory address width (matches the PC width)
INSTR_W, 10, instruction width
TIMEOUT, 255, maximum idle cycles allowed between accepted bytes during a load; 0 disables the timeout

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse that begins a load
rx_valid  input  1  byte-source data valid
rx_data  input  8  byte-source data
rx_ready  output  1  loader can accept a byte
imem_we  output  1  instruction memory write strobe
imem_addr  output  ADDR_W  write address
imem_wdata  output  INSTR_W  write data
cpu_hold  output  1  holds the CPU in reset
busy  output  1  load in progress
done  output  1  last load completed OK (sticky)
err_code  output  2  00 none, 01 format, 10 checksum, 11 timeout (sticky)

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including cpu_hold, so the CPU runs whatever is already in memory.
  - Counters, checksum and address are cleared.
- Byte transfer: a byte is accepted on a clock edge when rx_valid=1 and rx_ready=1.
  - rx_ready=1 only in LEN, HI, LO and CSUM.
- Frame format:
  - LEN: count N; the value 0 means 256.
  - Then N pairs of HI and LO bytes.
  - Then one CSUM byte equal to the XOR of all HI and LO bytes. The LEN byte is excluded.
- State machine:
  - IDLE: on start, go to LEN. Clear address, checksum, done and err_code; set busy=1 and cpu_hold=1.
  - LEN: on accept, latch the remaining count (N, or 256 when N=0). Go to HI.
  - HI: on accept, check bits [7:2].
    - If bits [7:2] are non-zero, go to ERR with err_code=01.
    - Otherwise store bits [1:0] as instr[9:8], XOR the byte into the checksum and go to LO.
  - LO: on accept, store the byte as instr[7:0], XOR it into the checksum and go to WRITE.
  - WRITE: imem_we=1 for exactly one cycle, with imem_addr = current address and imem_wdata = assembled instruction.
    - On the next edge: address increments by 1, wrapping modulo 2^ADDR_W, and the count decrements.
    - If the count reaches 0, go to CSUM; otherwise go to HI.
  - CSUM: on accept, compare the byte with the running checksum.
    - Equal: go to DONE.
    - Not equal: go to ERR with err_code=10.
  - DONE: done=1, busy=0, cpu_hold=0. On start, begin a new load (same action as IDLE).
  - ERR: busy=0, cpu_hold stays 1 so the CPU never runs a partial program. Only start or reset leaves ERR; start begins a new load.
- Timeout (TIMEOUT≠0):
  - An idle counter runs in LEN, HI, LO and CSUM.
  - It clears on every accepted byte and on every state entry.
  - When it reaches TIMEOUT with no accept, go to ERR with err_code=11.
  - If an accept and the TIMEOUT count happen on the same edge, the accept wins.
- Start pulses while busy=1 are ignored.
- imem_we is never asserted outside WRITE. Outputs are registered; imem_* are valid in the same cycle as imem_we.
- Reset during a load aborts immediately. No further writes occur, and memory contents already written are left as-is.

Test Plan:
- Valid load: start, then bytes 02,01,23,02,45,65 → two writes, addr 00 data 0x123 and addr 01 data 0x245, imem_we high 1 cycle each; then done=1, err_code=00, cpu_hold=0.
- Bad checksum: same frame with CSUM=00 → both writes occur; err_code=10, done=0, cpu_hold stays 1, busy=0.
- Format error: start, bytes 01,04 → ERR with err_code=01 on the HI accept; imem_we never asserted.
- Timeout: TIMEOUT=16; start, byte 03, then rx_valid held 0 → err_code=11 exactly 16 cycles after the LEN accept; stalling 15 cycles and then sending a byte raises no error.
- N=0: 256 instructions with pattern instr[i]={i[1:0],i} → 256 writes; address wraps 0xFF→0x00 after the last write; correct CSUM gives done=1.
- Reset mid-load: drop reset during LO of the 2nd instruction → all outputs 0 asynchronously; after release, state is IDLE and rx_ready=0; a new start loads correctly.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
// Writer side of the instruction-memory interface. Receives a program frame
// as a byte stream (LEN, N x {HI, LO}, CSUM), assembles 10-bit instructions
// and writes them sequentially into instruction memory starting at address 0.
// The CPU is held in reset while a load runs and after a failed load.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous, active-low reset
//   start      - single-cycle pulse that begins a load (ignored while busy)
//   rx_valid   - byte-source data valid
//   rx_data    - byte-source data
//   rx_ready   - loader can accept a byte (LEN, HI, LO, CSUM states)
//   imem_we    - instruction memory write strobe (one cycle per instruction)
//   imem_addr  - write address
//   imem_wdata - write data
//   cpu_hold   - holds the CPU in reset (load in progress or failed load)
//   busy       - load in progress
//   done       - last load completed OK (sticky until next start)
//   err_code   - 00 none, 01 format, 10 checksum, 11 timeout (sticky)
//   dbg_state  - current FSM state encoding, for observation only
//
// Handshake: a byte transfers on a rising edge where rx_valid=1 and
// rx_ready=1; rx_data must be stable while rx_valid=1, and rx_ready does not
// depend on rx_valid.
module program_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 10,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err_code,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    // Idle counter only needs to reach TIMEOUT-1: the edge that would make
    // it equal TIMEOUT is the edge that moves to ERR.
    localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [8:0]         cnt_q, cnt_d;      // remaining instructions, 1..256
    logic [7:0]         csum_q, csum_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [TW-1:0]      idle_q, idle_d;
    logic               done_d;
    logic [1:0]         err_d;
    logic               accept;
    logic               waiting;
    logic               timeout_hit;

    assign accept     = rx_valid && rx_ready;
    assign imem_addr  = addr_q;
    assign imem_wdata = instr_q;
    assign dbg_state  = state_q;

    assign waiting = (state_q == S_LEN) || (state_q == S_HI) ||
                     (state_q == S_LO)  || (state_q == S_CSUM);

    // An accepted byte on the same edge as the timeout wins.
    assign timeout_hit = (TIMEOUT != 0) && waiting && !accept &&
                         (idle_q == TW'(TO_LAST));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        instr_d = instr_q;
        done_d  = done;
        err_d   = err_code;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    addr_d  = '0;
                    csum_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 2'b00;
                end
            end
            S_LEN: begin
                if (accept) begin
                    cnt_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    if (|rx_data[7:2]) begin
                        state_d = S_ERR;
                        err_d   = 2'b01;
                    end else begin
                        instr_d[INSTR_W-1:8] = rx_data[INSTR_W-9:0];
                        csum_d  = csum_q ^ rx_data;
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                if (accept) begin
                    instr_d[7:0] = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - 9'd1;
                state_d = (cnt_q == 9'd1) ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 2'b10;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout_hit) begin
            state_d = S_ERR;
            err_d   = 2'b11;
        end

        // Idle counter restarts on every accept and on every state entry.
        if (TIMEOUT == 0 || accept || state_d != state_q || !waiting) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + TW'(1);
        end
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            csum_q   <= '0;
            instr_q  <= '0;
            idle_q   <= '0;
            done     <= 1'b0;
            err_code <= 2'b00;
            rx_ready <= 1'b0;
            imem_we  <= 1'b0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            instr_q  <= instr_d;
            idle_q   <= idle_d;
            done     <= done_d;
            err_code <= err_d;
            rx_ready <= (state_d == S_LEN) || (state_d == S_HI) ||
                        (state_d == S_LO)  || (state_d == S_CSUM);
            imem_we  <= (state_d == S_WRITE);
            busy     <= (state_d == S_LEN) || (state_d == S_HI) ||
                        (state_d == S_LO)  || (state_d == S_CSUM) ||
                        (state_d == S_WRITE);
            // ERR keeps the CPU held so a partial program never runs.
            cpu_hold <= (state_d == S_LEN) || (state_d == S_HI) ||
                        (state_d == S_LO)  || (state_d == S_CSUM) ||
                        (state_d == S_WRITE) || (state_d == S_ERR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 10;
  localparam int TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               rx_valid = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_hold;
  logic               busy;
  logic               done;
  logic [1:0]         err_code;
  logic [2:0]         dbg_state;

  program_loader #(
    .ADDR_W(ADDR_W),
    .INSTR_W(INSTR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .done(done),
    .err_code(err_code),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  int last_writes = 0;
  logic [17:0] exp_q[$];     // {addr[7:0], instr[9:0]}
  logic [7:0]  frame_q[$];
  int exp_done;
  int exp_err;
  int consumed;
  logic prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Parses the frame the way the loader must: expected writes into exp_q,
  // final done / err_code, and how many bytes the loader will consume.
  task automatic model_frame();
    int n;
    int a;
    logic [7:0] x;
    logic [7:0] hi;
    logic [7:0] lo;
    a = 0;
    x = 8'h00;
    n = (frame_q[0] == 8'h00) ? 256 : int'(frame_q[0]);
    consumed = 1;
    exp_err = 0;
    exp_done = 0;
    for (int i = 0; i < n; i++) begin
      hi = frame_q[1 + 2*i];
      consumed++;
      if (hi[7:2] != 6'd0) begin
        exp_err = 1;
        break;
      end
      lo = frame_q[2 + 2*i];
      consumed++;
      x = x ^ hi ^ lo;
      exp_q.push_back({a[7:0], hi[1:0], lo});
      a = (a + 1) % 256;
    end
    if (exp_err == 0) begin
      consumed++;
      if (frame_q[1 + 2*n] == x) exp_done = 1;
      else exp_err = 2;
    end
  endtask

  task automatic build_frame(input int n, input bit bad_csum, input int bad_idx);
    logic [7:0] x;
    logic [7:0] hi;
    logic [7:0] lo;
    x = 8'h00;
    frame_q.delete();
    frame_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      hi = 8'($urandom_range(0, 3));
      lo = 8'($urandom);
      if (i == bad_idx) hi = hi | 8'($urandom_range(1, 63) << 2);
      x = x ^ hi ^ lo;
      frame_q.push_back(hi);
      frame_q.push_back(lo);
    end
    frame_q.push_back(bad_csum ? ~x : x);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [17:0] e;
    if (reset) begin
      if (imem_we) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual_addr=%0h actual_data=%0h expected=none", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("imem_addr", imem_addr, e[17:10]);
          check("imem_wdata", imem_wdata, e[9:0]);
        end
        check("we_single_cycle", prev_we, 1'b0);
        check("we_no_ready", rx_ready, 1'b0);
      end
      check("hold_rule", cpu_hold, busy || (err_code != 2'b00));
      check("done_not_busy", done && busy, 1'b0);
      prev_we = imem_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = b;
      if (rx_ready) break;
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL rx_ready_wait actual=0 expected=1");
        rx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input bit stall);
    int w0;
    model_frame();
    w0 = writes_seen;
    pulse_start();
    for (int i = 0; i < consumed; i++) begin
      if (i == 1 && stall) gap(TIMEOUT - 1);
      else gap($urandom_range(0, 3));
      send_byte(frame_q[i]);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("done", done, exp_done);
    check("err_code", err_code, exp_err);
    check("busy_end", busy, 1'b0);
    check("cpu_hold_end", cpu_hold, (exp_done == 1) ? 1'b0 : 1'b1);
    check("rx_ready_end", rx_ready, 1'b0);
    check("pending_writes", exp_q.size(), 0);
    last_writes = writes_seen - w0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", rx_ready, 1'b0);

    // Valid load from the reference frame; pin the model with literals.
    frame_q = '{8'h02, 8'h01, 8'h23, 8'h02, 8'h45, 8'h65};
    model_frame();
    check("model_w0", exp_q[0], {8'h00, 10'h123});
    check("model_w1", exp_q[1], {8'h01, 10'h245});
    check("model_done", exp_done, 1);
    exp_q.delete();
    run_frame(1'b0);
    check("valid_writes", last_writes, 2);
    check("valid_done_lit", done, 1'b1);
    check("valid_addr_after", imem_addr, 8'h02);

    // Bad checksum.
    frame_q = '{8'h02, 8'h01, 8'h23, 8'h02, 8'h45, 8'h00};
    run_frame(1'b0);
    check("csum_writes", last_writes, 2);
    check("csum_err_lit", err_code, 2'b10);

    // Format error on the first HI byte.
    frame_q = '{8'h01, 8'h04};
    run_frame(1'b0);
    check("fmt_writes", last_writes, 0);
    check("fmt_err_lit", err_code, 2'b01);

    // Timeout: LEN accepted, then silence.
    pulse_start();
    send_byte(8'h03);
    gap(TIMEOUT - 1);
    @(negedge clk);
    check("to_early_err", err_code, 2'b00);
    check("to_early_busy", busy, 1'b1);
    @(negedge clk);
    check("to_err", err_code, 2'b11);
    check("to_busy", busy, 1'b0);
    check("to_hold", cpu_hold, 1'b1);
    check("to_ready", rx_ready, 1'b0);

    // Stall of TIMEOUT-1 cycles: byte lands on the timeout edge and wins.
    build_frame(3, 1'b0, -1);
    run_frame(1'b1);
    check("stall_writes", last_writes, 3);

    // N=0 means 256 instructions; address wraps after the last write.
    begin
      logic [7:0] x;
      x = 8'h00;
      frame_q.delete();
      frame_q.push_back(8'h00);
      for (int i = 0; i < 256; i++) begin
        logic [7:0] v;
        v = 8'(i);
        frame_q.push_back({6'd0, v[1:0]});
        frame_q.push_back(v);
        x = x ^ {6'd0, v[1:0]} ^ v;
      end
      frame_q.push_back(x);
    end
    run_frame(1'b0);
    check("n0_writes", last_writes, 256);
    check("n0_addr_wrap", imem_addr, 8'h00);
    check("n0_done", done, 1'b1);

    // Reset in LO of the second instruction.
    build_frame(3, 1'b0, -1);
    model_frame();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      gap($urandom_range(0, 3));
      send_byte(frame_q[i]);
    end
    gap($urandom_range(1, 5));
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midload");
    check("midload_left", exp_q.size(), 2);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_ready", rx_ready, 1'b0);
    check("post_reset_state", dbg_state, 3'd0);
    check("post_reset_busy", busy, 1'b0);
    build_frame(4, 1'b0, -1);
    run_frame(1'b0);
    check("post_reset_writes", last_writes, 4);

    // Randomized frames: mixture of good, bad checksum and format errors.
    for (int k = 0; k < 10; k++) begin
      int n;
      int kind;
      n = $urandom_range(1, 12);
      kind = $urandom_range(0, 3);
      build_frame(n, kind == 1, (kind == 2) ? int'($urandom_range(0, n - 1)) : -1);
      run_frame(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
